// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and FSM state type for alu_pipe
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_ORR  = 4'b0100;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_LSL  = 4'b1110;
  localparam logic [3:0] OP_LSR  = 4'b1111;
  localparam logic [3:0] OP_MUL  = 4'b0011;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier, one bit of b per cycle
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_acc_next;

  // Multiplicand walks left, multiplier walks right; bits above WIDTH drop off.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CNT_LAST);
  assign product = w_acc_next;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with NZCV flags, shifts and iterative multiply
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_one,
  input  logic [WIDTH-1:0] in_two,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             overflow_flag
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_product;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_ovf;
  logic [SHAMT_W-1:0] w_shamt;

  assign in_ready = (r_state == ST_IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (opcode == OP_MUL);

  assign w_add   = {1'b0, in_one} + {1'b0, in_two};
  assign w_sub   = {1'b0, in_one} + {1'b0, ~in_two} + {{WIDTH{1'b0}}, 1'b1};
  assign w_shamt = in_two[SHAMT_W-1:0];

  // Shift amounts >= WIDTH fall out of the word, leaving 0.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (in_one[WIDTH-1] == in_two[WIDTH-1]) && (w_add[WIDTH-1] != in_one[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_sub[WIDTH-1:0];
        w_carry = w_sub[WIDTH];
        w_ovf   = (in_one[WIDTH-1] != in_two[WIDTH-1]) && (w_sub[WIDTH-1] != in_one[WIDTH-1]);
      end
      OP_CBZ:  w_res = {{(WIDTH-1){1'b0}}, ~|in_one};
      OP_AND:  w_res = in_one & in_two;
      OP_ORR:  w_res = in_one | in_two;
      OP_EOR:  w_res = in_one ^ in_two;
      OP_NOR:  w_res = ~(in_one | in_two);
      OP_NAND: w_res = ~(in_one & in_two);
      OP_MOV:  w_res = in_one;
      OP_LSL:  w_res = in_one << w_shamt;
      OP_LSR:  w_res = in_one >> w_shamt;
      default: w_res = '0;
    endcase
  end

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (w_accept && w_is_mul),
    .a       (in_one),
    .b       (in_two),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && w_is_mul) w_next_state = ST_MUL_RUN;
      ST_MUL_RUN: if (w_mul_done)           w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_neg       <= w_res[WIDTH-1];
      r_carry     <= w_carry;
      r_ovf       <= w_ovf;
    end else if (w_accept) begin
      // A MUL is only accepted once the previous result has been taken.
      r_out_valid <= 1'b0;
    end else if (w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_product;
      r_zero      <= (w_product == '0);
      r_neg       <= w_product[WIDTH-1];
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign result        = r_result;
  assign zero_flag     = r_zero;
  assign neg_flag      = r_neg;
  assign carry_flag    = r_carry;
  assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and randomized self-checking bench for alu_pipe
module tb_alu_pipe;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_one;
  logic [31:0] in_two;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero_flag;
  logic        neg_flag;
  logic        carry_flag;
  logic        overflow_flag;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(32), .SHAMT_W(6)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_one        (in_one),
    .in_two        (in_two),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .zero_flag     (zero_flag),
    .neg_flag      (neg_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each opcode.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v);
    longint sa;
    longint sb;
    longint s;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0010: begin
        r = a + b;
        c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1010: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = (a == 0) ? 32'd1 : 32'd0;
      4'b0110: r = a & b;
      4'b0100: r = a | b;
      4'b1001: r = a ^ b;
      4'b0101: r = ~(a | b);
      4'b1100: r = ~(a & b);
      4'b1101: r = a;
      4'b1110: r = (b[5:0] >= 6'd32) ? 32'd0 : (a << b[5:0]);
      4'b1111: r = (b[5:0] >= 6'd32) ? 32'd0 : (a >> b[5:0]);
      4'b0011: begin
        p = 64'(a) * 64'(b);
        r = p[31:0];
      end
      default: r = 32'd0;
    endcase
  endfunction

  task automatic check_out(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic ec;
    logic ev;
    model(op, a, b, er, ec, ev);
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, 64'(result), 64'(er));
    check({tag, "_zncv"}, 64'({zero_flag, neg_flag, carry_flag, overflow_flag}),
          64'({er == 32'd0, er[31], ec, ev}));
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    opcode = op; in_one = a; in_two = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check_out(tag, op, a, b);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    bit ready_seen;
    @(negedge clock);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
    opcode = 4'b0011; in_one = a; in_two = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    // Junk on the inputs while the multiply runs must be ignored.
    opcode = 4'b0010; in_one = $urandom; in_two = $urandom;
    cyc = 1;
    ready_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      @(negedge clock);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 64'(cyc), 64'd33);
    check({tag, "_busy_rdy"}, 64'(ready_seen), 64'd0);
    check_out(tag, 4'b0011, a, b);
  endtask

  initial begin
    logic [3:0]  p_op;
    logic [31:0] p_a;
    logic [31:0] p_b;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit stray;

    // Reset held two edges while an ADD is offered: nothing may be captured.
    reset_n = 1'b0; in_valid = 1'b1; opcode = 4'b0010; in_one = 32'd1; in_two = 32'd2; out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_flags", 64'({zero_flag, neg_flag, carry_flag, overflow_flag}), 64'd0);
    reset_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rst_rdy", 64'(in_ready), 64'd1);

    run_single("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf_const", 64'({result, neg_flag, zero_flag, carry_flag, overflow_flag}),
          64'({32'h8000_0000, 4'b1001}));
    run_single("sub_eq", 4'b1010, 32'd5, 32'd5);
    check("sub_eq_const", 64'({result, neg_flag, zero_flag, carry_flag, overflow_flag}),
          64'({32'd0, 4'b0110}));

    // Back-pressure with a NAND queued behind a stalled ORR.
    @(negedge clock);
    opcode = 4'b0100; in_one = 32'd5; in_two = 32'd10; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    opcode = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      check("bp_vld", 64'(out_valid), 64'd1);
      check("bp_res", 64'(result), 64'd15);
      check("bp_rdy", 64'(in_ready), 64'd0);
      if (i < 2) @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    check("bp_nand_vld", 64'(out_valid), 64'd1);
    check("bp_nand_res", 64'(result), 64'hFFFF_FFFF);

    run_mul("mul_7x6", 32'd7, 32'd6);
    check("mul_7x6_const", 64'(result), 64'd42);
    run_mul("mul_neg", 32'hFFFF_FFFF, 32'd2);
    check("mul_neg_const", 64'(result), 64'hFFFF_FFFE);

    run_single("lsl31", 4'b1110, 32'd1, 32'd31);
    check("lsl31_const", 64'(result), 64'h8000_0000);
    run_single("lsr40", 4'b1111, 32'h8000_0000, 32'd40);
    check("lsr40_const", 64'(result), 64'd0);
    run_single("cbz0", 4'b0111, 32'd0, 32'd3);
    check("cbz0_const", 64'(result), 64'd1);
    run_single("cbz10", 4'b0111, 32'd10, 32'd3);
    check("cbz10_const", 64'(result), 64'd0);
    run_single("undef", 4'b0000, 32'd9, 32'd9);
    check("undef_const", 64'({result, zero_flag}), 64'({32'd0, 1'b1}));

    // Reset in the tenth cycle of a multiply.
    @(negedge clock);
    opcode = 4'b0011; in_one = 32'd123; in_two = 32'd45; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("midrst_vld", 64'(out_valid), 64'd0);
    check("midrst_rdy", 64'(in_ready), 64'd1);
    stray = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    check("midrst_no_out", 64'(stray), 64'd0);
    run_single("post_rst_add", 4'b0010, 32'd15, 32'd15);
    check("post_rst_add_const", 64'(result), 64'd30);

    // Random single-cycle ops streamed back to back at full throughput.
    p_op = '0; p_a = '0; p_b = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (i > 0) check_out("rnd", p_op, p_a, p_b);
      check("rnd_rdy", 64'(in_ready), 64'd1);
      op = 4'($urandom_range(0, 15));
      if (op == 4'b0011) op = 4'b1010;
      case ($urandom_range(0, 3))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      opcode = op; in_one = a; in_two = b; in_valid = 1'b1; out_ready = 1'b1;
      p_op = op; p_a = a; p_b = b;
    end
    @(negedge clock);
    in_valid = 1'b0;
    check_out("rnd_last", p_op, p_a, p_b);

    for (int i = 0; i < 4; i++) run_mul("rnd_mul", $urandom, $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Sits between the register-read stage and the writeback/branch stage of the ARM-LP core.
- Keeps the core 4-bit opcode set; NOR/NAND are strictly bitwise.
- Adds NZCV flags, logical shifts, an iterative multiply and valid/ready flow control on both sides.

Parameters:
- WIDTH, 32: operand/result width in bits (≥ 8).
- SHAMT_W, 6: bits of in_two used as the shift amount for LSL/LSR; larger amounts saturate the result to 0.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  operand/opcode present
- in_ready  out  1  block can accept this cycle
- in_one  in  WIDTH  operand A
- in_two  in  WIDTH  operand B / shift amount
- opcode  in  4  operation select
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero_flag  out  1  result == 0
- neg_flag  out  1  result[WIDTH-1]
- carry_flag  out  1  carry out (ADD) / no-borrow (SUB); 0 for other ops
- overflow_flag  out  1  signed overflow (ADD/SUB); 0 for other ops

Behaviour:
- Reset: reset_n sampled low at a clock edge clears the following:
  - result and all flags to 0; out_valid to 0; FSM to IDLE; multiplier accumulator and counter to 0.
- Reset mid-operation: aborts any multiply in progress and discards any held output.
- Accept condition: in_valid && in_ready at a rising edge.
- Ready: in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational and independent of in_valid.
- Opcodes (result, width WIDTH, wraps modulo 2^WIDTH):
  - 0010 ADD: A+B
  - 1010 SUB: A-B
  - 0111 CBZ: 1 if A==0 else 0
  - 0110 AND: A&B
  - 0100 ORR: A|B
  - 1001 EOR: A^B
  - 0101 NOR: ~(A|B)
  - 1100 NAND: ~(A&B)
  - 1101 MOV: A
  - 1110 LSL: A << B[SHAMT_W-1:0]
  - 1111 LSR: A >> B[SHAMT_W-1:0]
  - 0011 MUL: low WIDTH bits of A*B
  - other: result 0, flags computed normally (zero_flag=1)
- Flags:
  - carry = bit WIDTH of the (WIDTH+1)-bit sum A+B, or of A+~B+1 for SUB.
  - overflow = operands' signs agree (for SUB, A's sign vs ~B's) and result sign differs.
- Single-cycle ops: result/flags registered at the accept edge; out_valid high the next cycle (latency 1).
- Output hold: result, flags and out_valid hold stable while out_valid && !out_ready. out_valid drops at an edge with out_ready=1 unless a new op is accepted at the same edge.
- Back-to-back: an output consumed and a new op accepted at the same edge is allowed. Full throughput is one single-cycle op per clock.
- FSM states:
  - IDLE: accepting ops.
  - MUL_RUN: shift-add, one bit of B per cycle, counter 0..WIDTH-1.
  - IDLE → MUL_RUN: MUL accepted.
  - MUL_RUN → IDLE: when counter == WIDTH-1. Product is registered into result at that edge, out_valid=1.
  - MUL latency: WIDTH+1 edges from accept to out_valid (the counter's final cycle loads result).
- MUL operands: latched at accept; in_* ignored during MUL_RUN. in_ready=0 throughout MUL_RUN.
- A MUL may be accepted while a previous result waits only if out_ready=1 that cycle (per the ready rule).
- Simultaneous reset and accept: reset wins; nothing is captured.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD, OP_SUB, OP_CBZ, OP_AND, OP_ORR, OP_EOR, OP_NOR, OP_NAND, OP_MOV, OP_LSL, OP_LSR, OP_MUL)
  - FSM state encoding (ST_IDLE, ST_MUL_RUN)
- One sub-module: alu_mul_seq.
  - Parametrised WIDTH; contains the iterative shift-add multiplier and its counter.
  - Ports: clock, reset_n, start, a, b, busy, done, product.
- Top holds the combinational op mux, flag logic, output register and handshake.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with in_valid=1 → out_valid=0, result=0, all flags 0, in_ready=1 after release.
- ADD A=0x7FFFFFFF B=1 → result 0x80000000, N=1 Z=0 C=0 V=1, latency 1. Then SUB A=5 B=5 → result 0, Z=1 C=1 V=0.
- Back-pressure: ORR 5|10 accepted, out_ready=0 for 3 cycles → result 15 held stable, in_ready=0. Raise out_ready with a queued NAND 5,10 → next cycle result 0xFFFFFFFF, no gap.
- MUL A=7 B=6 (WIDTH=32) → in_ready=0 during run, out_valid exactly 33 cycles after accept, result 42. A=0xFFFFFFFF B=2 → 0xFFFFFFFE.
- Shifts/CBZ/undefined:
  - LSL 1 by 31 → 0x80000000; LSR 0x80000000 by 40 → 0.
  - CBZ A=0 → 1; CBZ A=10 → 0.
  - opcode 0000 → result 0, Z=1.
- Reset mid-MUL: reset_n=0 at cycle 10 of a MUL → no out_valid, FSM IDLE; a subsequent ADD 15+15 → 30 with latency 1.
